// File: rtl/pulse_stretcher.sv
// Pulse stretcher: turns a one-cycle trigger into a level held for
// duration * TICK_DIV clocks, with retrigger, cancel and an expiry pulse.
module pulse_stretcher #(
    parameter int unsigned CLK_FREQ  = 50_000_000,
    parameter int unsigned TICK_FREQ = 1_000,
    parameter int unsigned WIDTH     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             trig_in,
    input  logic [WIDTH-1:0] duration,
    input  logic             retrigger_en,
    input  logic             cancel,
    output logic             pulse_out,
    output logic             busy,
    output logic             done
);

    // TICK_DIV must be at least 2 so the prescaler has a non-zero width.
    localparam int unsigned TICK_DIV = CLK_FREQ / TICK_FREQ;
    localparam int unsigned PSC_W    = $clog2(TICK_DIV);
    localparam logic [PSC_W-1:0] PSC_LAST = PSC_W'(TICK_DIV - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_HOLD = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           r_state;
    logic [WIDTH-1:0] r_rem;
    logic [PSC_W-1:0] r_psc;

    state_t           w_state_nxt;
    logic [WIDTH-1:0] w_rem_nxt;
    logic [PSC_W-1:0] w_psc_nxt;
    logic             w_pulse_nxt;
    logic             w_busy_nxt;
    logic             w_done_nxt;

    logic w_dur_ok;
    logic w_tick;

    assign w_dur_ok = (duration != '0);
    assign w_tick   = (r_psc == PSC_LAST);

    // State register, remaining-ticks counter and prescaler
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_rem   <= '0;
            r_psc   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_rem   <= w_rem_nxt;
            r_psc   <= w_psc_nxt;
        end
    end

    // Next-state logic; the prescaler defaults to 0 so it idles outside HOLD
    always_comb begin
        w_state_nxt = r_state;
        w_rem_nxt   = r_rem;
        w_psc_nxt   = '0;
        case (r_state)
            S_IDLE, S_DONE: begin
                w_state_nxt = S_IDLE;
                if (trig_in && w_dur_ok && !cancel) begin
                    w_state_nxt = S_HOLD;
                    w_rem_nxt   = duration;
                end
            end
            S_HOLD: begin
                if (cancel) begin
                    w_state_nxt = S_IDLE;
                    w_rem_nxt   = '0;
                end else if (trig_in && retrigger_en && w_dur_ok) begin
                    w_rem_nxt = duration;
                end else if (w_tick) begin
                    if (r_rem != '0) begin
                        w_rem_nxt = r_rem - WIDTH'(1);
                    end
                    if (r_rem <= WIDTH'(1)) begin
                        w_state_nxt = S_DONE;
                    end
                end else begin
                    w_psc_nxt = r_psc + PSC_W'(1);
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_rem_nxt   = '0;
            end
        endcase
    end

    // Output decode from the upcoming state so the registered outputs align with it
    always_comb begin
        w_pulse_nxt = 1'b0;
        w_busy_nxt  = 1'b0;
        w_done_nxt  = 1'b0;
        case (w_state_nxt)
            S_HOLD: begin
                w_pulse_nxt = 1'b1;
                w_busy_nxt  = 1'b1;
            end
            S_DONE:  w_done_nxt = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pulse_out <= 1'b0;
            busy      <= 1'b0;
            done      <= 1'b0;
        end else begin
            pulse_out <= w_pulse_nxt;
            busy      <= w_busy_nxt;
            done      <= w_done_nxt;
        end
    end

endmodule

// File: tb/tb_pulse_stretcher.sv
// Bench for pulse_stretcher: directed scenarios plus random traffic checked
// against a cycle-count model of the hold (no prescaler/remaining split).
module tb_pulse_stretcher;

    localparam int unsigned CLK_FREQ  = 10;
    localparam int unsigned TICK_FREQ = 2;
    localparam int unsigned WIDTH     = 8;
    localparam int TD = CLK_FREQ / TICK_FREQ;

    logic             clk = 1'b0;
    logic             rst;
    logic             trig_in;
    logic [WIDTH-1:0] duration;
    logic             retrigger_en;
    logic             cancel;
    logic             pulse_out;
    logic             busy;
    logic             done;

    int n_cmp = 0;
    int n_err = 0;
    int n_width;
    int n_done;

    // Model: hold is just "cycles of high output left"
    bit m_act  = 1'b0;
    int m_left = 0;
    bit m_done = 1'b0;

    pulse_stretcher #(
        .CLK_FREQ (CLK_FREQ),
        .TICK_FREQ(TICK_FREQ),
        .WIDTH    (WIDTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .trig_in     (trig_in),
        .duration    (duration),
        .retrigger_en(retrigger_en),
        .cancel      (cancel),
        .pulse_out   (pulse_out),
        .busy        (busy),
        .done        (done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0d expected %0d", tag, $time, got, exp);
        end
    endtask

    task automatic model_update(input logic t, input logic [WIDTH-1:0] d,
                                input logic re, input logic c, input logic rs);
        if (rs) begin
            m_act  = 1'b0;
            m_left = 0;
            m_done = 1'b0;
        end else if (m_act) begin
            m_done = 1'b0;
            if (c) begin
                m_act = 1'b0;
            end else if (t && re && d != 0) begin
                m_left = int'(d) * TD;
            end else begin
                m_left--;
                if (m_left == 0) begin
                    m_act  = 1'b0;
                    m_done = 1'b1;
                end
            end
        end else begin
            m_done = 1'b0;
            if (t && d != 0 && !c) begin
                m_act  = 1'b1;
                m_left = int'(d) * TD;
            end
        end
    endtask

    task automatic step(input logic t, input logic [WIDTH-1:0] d,
                        input logic re, input logic c, input logic rs);
        trig_in      = t;
        duration     = d;
        retrigger_en = re;
        cancel       = c;
        rst          = rs;
        @(posedge clk);
        model_update(t, d, re, c, rs);
        #1;
        chk("pulse_out", 32'(pulse_out), 32'(m_act));
        chk("busy", 32'(busy), 32'(m_act));
        chk("done", 32'(done), 32'(m_done));
        if (pulse_out === 1'b1) n_width++;
        if (done === 1'b1) n_done++;
    endtask

    task automatic idle(input int n, input logic re);
        for (int i = 0; i < n; i++) step(1'b0, WIDTH'($urandom), re, 1'b0, 1'b0);
    endtask

    initial begin
        trig_in = 1'b0; duration = '0; retrigger_en = 1'b0; cancel = 1'b0; rst = 1'b1;

        // Reset, then trigger on the very first cycle out of reset
        step(1'b1, 8'd5, 1'b0, 1'b0, 1'b1);
        step(1'b1, 8'd5, 1'b1, 1'b1, 1'b1);
        n_width = 0; n_done = 0;
        step(1'b1, 8'd3, 1'b0, 1'b0, 1'b0);
        idle(20, 1'b0);
        chk("basic_width", 32'(n_width), 32'd15);
        chk("basic_done", 32'(n_done), 32'd1);

        // Zero duration is ignored
        n_width = 0; n_done = 0;
        step(1'b1, 8'd0, 1'b1, 1'b0, 1'b0);
        idle(3, 1'b0);
        chk("zero_width", 32'(n_width), 32'd0);
        chk("zero_done", 32'(n_done), 32'd0);

        // Trigger during hold without retrigger enable is ignored
        n_width = 0; n_done = 0;
        step(1'b1, 8'd3, 1'b0, 1'b0, 1'b0);
        idle(6, 1'b0);
        step(1'b1, 8'd3, 1'b0, 1'b0, 1'b0);
        idle(20, 1'b0);
        chk("noretrig_width", 32'(n_width), 32'd15);
        chk("noretrig_done", 32'(n_done), 32'd1);

        // Retrigger 7 cycles in with duration 2
        n_width = 0; n_done = 0;
        step(1'b1, 8'd3, 1'b1, 1'b0, 1'b0);
        idle(6, 1'b1);
        step(1'b1, 8'd2, 1'b1, 1'b0, 1'b0);
        idle(20, 1'b1);
        chk("retrig_width", 32'(n_width), 32'd17);
        chk("retrig_done", 32'(n_done), 32'd1);

        // Cancel wins over a simultaneous trigger
        n_width = 0; n_done = 0;
        step(1'b1, 8'd3, 1'b1, 1'b0, 1'b0);
        idle(3, 1'b1);
        step(1'b1, 8'd3, 1'b1, 1'b1, 1'b0);
        chk("cancel_low", 32'(pulse_out), 32'd0);
        idle(20, 1'b0);
        chk("cancel_width", 32'(n_width), 32'd4);
        chk("cancel_done", 32'(n_done), 32'd0);

        // Back-to-back: trigger presented during the DONE cycle
        n_width = 0; n_done = 0;
        step(1'b1, 8'd1, 1'b0, 1'b0, 1'b0);
        idle(5, 1'b0);
        chk("b2b_done_cycle", 32'(done), 32'd1);
        step(1'b1, 8'd1, 1'b0, 1'b0, 1'b0);
        chk("b2b_rehold", 32'(pulse_out), 32'd1);
        idle(10, 1'b0);
        chk("b2b_width", 32'(n_width), 32'd10);
        chk("b2b_done", 32'(n_done), 32'd2);

        // Reset mid-hold, then a full pulse right after
        step(1'b1, 8'd3, 1'b0, 1'b0, 1'b0);
        idle(4, 1'b0);
        step(1'b1, 8'd3, 1'b1, 1'b0, 1'b1);
        chk("rst_outs", 32'({pulse_out, busy, done}), 32'd0);
        n_width = 0; n_done = 0;
        step(1'b1, 8'd2, 1'b0, 1'b0, 1'b0);
        idle(15, 1'b0);
        chk("rst_width", 32'(n_width), 32'd10);
        chk("rst_done", 32'(n_done), 32'd1);

        // Random traffic against the model
        for (int i = 0; i < 3000; i++) begin
            logic t, re, c, rs;
            logic [WIDTH-1:0] d;
            t  = ($urandom_range(7) == 0);
            re = $urandom_range(1);
            c  = ($urandom_range(24) == 0);
            rs = ($urandom_range(149) == 0);
            d  = ($urandom_range(9) == 0) ? WIDTH'($urandom_range(8)) : WIDTH'($urandom_range(3));
            step(t, d, re, c, rs);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
